// File: rtl/clock_phase_gen.sv
// clock_phase_gen: multi-phase processor clock-enable generator.
// Produces a phase counter with phase-advance (tick) and end-of-cycle
// (cycle_done) strobes from a programmable prescaler, with run/stop/step
// control. Every output is a registered enable in the clkin domain.
//
// state       | meaning
// ------------+------------------------------------------------------
// IDLE        | stopped; phase and prescaler held
// RUN         | free-running, phases advance continuously
// STEP_WAIT   | step mode, waiting for step_req
// STEP_ACTIVE | executing one processor cycle up to the next phase wrap
module clock_phase_gen #(
    parameter int DIV_W  = 8,
    parameter int PHASES = 2,
    parameter int PH_W   = 1
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       mode,
    input  logic             step_req,
    output logic [PH_W-1:0]  phase,
    output logic             tick,
    output logic             cycle_done,
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        RUN         = 2'd1,
        STEP_WAIT   = 2'd2,
        STEP_ACTIVE = 2'd3
    } state_t;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] pre_q, pre_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             tick_q, cycle_done_q, running_q;

    logic adv_en;
    logic fire;
    logic wrap;
    logic mode_stop;
    logic mode_step;
    logic mode_run;

    assign mode_stop = (mode == 2'b00);
    assign mode_step = (mode == 2'b10);
    assign mode_run  = mode[0];

    assign adv_en = (state_q == RUN) || (state_q == STEP_ACTIVE);
    assign fire   = adv_en && (pre_q == div_q);
    assign wrap   = fire && (phase_q == PH_LAST);

    // Prescaler and phase counter next-state; the ratio is only reloaded at
    // terminal count so a mid-interval div change never distorts the current one.
    always_comb begin
        pre_d   = pre_q;
        div_d   = div_q;
        phase_d = phase_q;
        if (adv_en) begin
            if (fire) begin
                pre_d   = '0;
                div_d   = div;
                phase_d = wrap ? '0 : phase_q + 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end else begin
            div_d = div;
        end
    end

    // Mode/step FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mode_run)       state_d = RUN;
                else if (mode_step) state_d = STEP_WAIT;
            end
            RUN: begin
                if (mode_stop)      state_d = IDLE;
                else if (mode_step) state_d = STEP_WAIT;
            end
            STEP_WAIT: begin
                if (mode_stop)      state_d = IDLE;
                else if (mode_run)  state_d = RUN;
                else if (step_req)  state_d = STEP_ACTIVE;
            end
            STEP_ACTIVE: begin
                if (mode_stop)      state_d = IDLE;
                else if (mode_run)  state_d = RUN;
                else if (wrap)      state_d = STEP_WAIT;
            end
            default:                state_d = IDLE;
        endcase
    end

    // State, counters and registered output strobes.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pre_q        <= '0;
            div_q        <= '0;
            phase_q      <= '0;
            tick_q       <= 1'b0;
            cycle_done_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            div_q        <= div_d;
            phase_q      <= phase_d;
            tick_q       <= fire;
            cycle_done_q <= wrap;
            running_q    <= (state_d == RUN) || (state_d == STEP_ACTIVE);
        end
    end

    assign phase      = phase_q;
    assign tick       = tick_q;
    assign cycle_done = cycle_done_q;
    assign running    = running_q;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Directed testbench for clock_phase_gen: a 2-phase instance and a 3-phase
// instance, with hand-computed expectations.
module tb_clock_phase_gen;

    logic       clk;
    logic       rst_n;
    logic [7:0] div;
    logic [1:0] mode;
    logic       step_req;
    logic       phase;
    logic       tick;
    logic       cycle_done;
    logic       running;

    logic [7:0] div2;
    logic [1:0] mode2;
    logic       step_req2;
    logic [1:0] phase2;
    logic       tick2;
    logic       cycle_done2;
    logic       running2;

    int n_checks = 0;
    int n_errors = 0;

    clock_phase_gen #(.DIV_W(8), .PHASES(2), .PH_W(1)) dut (
        .clkin      (clk),
        .reset      (rst_n),
        .div        (div),
        .mode       (mode),
        .step_req   (step_req),
        .phase      (phase),
        .tick       (tick),
        .cycle_done (cycle_done),
        .running    (running)
    );

    clock_phase_gen #(.DIV_W(8), .PHASES(3), .PH_W(2)) dut3 (
        .clkin      (clk),
        .reset      (rst_n),
        .div        (div2),
        .mode       (mode2),
        .step_req   (step_req2),
        .phase      (phase2),
        .tick       (tick2),
        .cycle_done (cycle_done2),
        .running    (running2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int ticks;
    int cds;

    initial begin
        rst_n     = 1'b0;
        div       = 8'd0;
        mode      = 2'b00;
        step_req  = 1'b0;
        div2      = 8'd0;
        mode2     = 2'b00;
        step_req2 = 1'b0;

        // Reset state
        cyc();
        cyc();
        check("rst_phase", phase, 0);
        check("rst_tick", tick, 0);
        check("rst_cd", cycle_done, 0);
        check("rst_running", running, 0);
        check("rst_phase3", phase2, 0);

        // div=0 run: toggle every cycle (2-phase), 0,1,2,0 (3-phase)
        mode  = 2'b01;
        mode2 = 2'b01;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check("t1_entry_running", running, 1);
        check("t1_entry_tick", tick, 0);
        check("t1_entry_phase", phase, 0);
        check("t1_entry_running3", running2, 1);
        for (int i = 1; i <= 7; i++) begin
            cyc();
            check("t1_phase", phase, i % 2);
            check("t1_tick", tick, 1);
            check("t1_cd", cycle_done, (i % 2 == 0) ? 1 : 0);
            check("t4_phase3", phase2, i % 3);
            check("t4_tick3", tick2, 1);
            check("t4_cd3", cycle_done2, (i % 3 == 0) ? 1 : 0);
        end

        // div=3 run: tick every 4th cycle, cycle_done every 8th
        rst_n = 1'b0;
        mode  = 2'b01;
        div   = 8'd3;
        mode2 = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check("t2_entry_running", running, 1);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            check("t2_tick", tick, (k % 4 == 0) ? 1 : 0);
            check("t2_phase", phase, (k / 4) % 2);
            check("t2_cd", cycle_done, (k % 8 == 0) ? 1 : 0);
        end

        // div change to 1 at pre=1: current interval stays 4, then 2
        cyc();
        div = 8'd1;
        for (int k = 18; k <= 24; k++) begin
            cyc();
            check("t3_tick", tick, (k == 20 || k == 22 || k == 24) ? 1 : 0);
        end
        check("t3_phase", phase, 1);

        // Single step, div=1; second request during step ignored
        rst_n    = 1'b0;
        mode     = 2'b10;
        div      = 8'd1;
        step_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check("t5_wait_running", running, 0);
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        check("t5_active_running", running, 1);
        ticks = 0;
        cds   = 0;
        for (int j = 3; j <= 10; j++) begin
            if (j == 5) step_req = 1'b1;
            cyc();
            step_req = 1'b0;
            if (tick) ticks++;
            if (cycle_done) cds++;
        end
        check("t5_ticks", ticks, 2);
        check("t5_cds", cds, 1);
        check("t5_phase", phase, 0);
        check("t5_running", running, 0);

        // Reset asserted in STEP_ACTIVE with phase=1
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        cyc();
        cyc();
        check("t6_pre_phase", phase, 1);
        check("t6_pre_running", running, 1);
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_phase", phase, 0);
        check("t6_async_tick", tick, 0);
        check("t6_async_cd", cycle_done, 0);
        check("t6_async_running", running, 0);
        mode = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cyc();
            check("t6_release_outs", {phase, tick, cycle_done, running}, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
